// File: rtl/vram_responder.sv
// RAM-side responder for the 256-bit vector load/store port: byte-lane writable storage,
// fixed-latency read pipeline, sticky out-of-range flag and access counters.
module vram_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned READ_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [13:0]  address_RAM,
  input  logic [31:0]  byteena_RAM,
  input  logic [255:0] writeData_RAM,
  input  logic         rden_RAM,
  input  logic         wren_RAM,
  output logic [255:0] readData_RAM,
  output logic         rvalid_RAM,
  output logic         err_oor,
  output logic [31:0]  read_count,
  output logic [31:0]  write_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [255:0]        mem [DEPTH];
  logic [AW-1:0]       word_idx;
  logic                in_range;
  logic [READ_LAT-1:0] pipe_valid;
  logic [255:0]        pipe_data [READ_LAT];

  // Full 14-bit compare so addresses beyond DEPTH never alias onto real words.
  assign in_range = {18'd0, address_RAM} < DEPTH;
  assign word_idx = address_RAM[AW-1:0];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin : storage
    if (wren_RAM && in_range) begin
      for (int i = 0; i < 32; i++) begin
        if (byteena_RAM[i]) begin
          mem[word_idx][8*i +: 8] <= writeData_RAM[8*i +: 8];
        end
      end
    end
  end

  // Read data is captured at the sampling edge, so a same-edge write is not yet visible.
  always_ff @(posedge clk) begin : read_data_pipe
    if (rden_RAM) begin
      pipe_data[0] <= in_range ? mem[word_idx] : '0;
    end
    for (int s = 1; s < READ_LAT; s++) begin
      pipe_data[s] <= pipe_data[s-1];
    end
  end

  always_ff @(posedge clk) begin : read_valid_pipe
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rden_RAM;
      for (int s = 1; s < READ_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin : outputs
    if (reset) begin
      readData_RAM <= '0;
      rvalid_RAM   <= 1'b0;
      err_oor      <= 1'b0;
      read_count   <= '0;
      write_count  <= '0;
    end else begin
      rvalid_RAM <= pipe_valid[READ_LAT-1];
      if (pipe_valid[READ_LAT-1]) begin
        readData_RAM <= pipe_data[READ_LAT-1];
      end
      if ((rden_RAM || wren_RAM) && !in_range) begin
        err_oor <= 1'b1;
      end
      if (rden_RAM) begin
        read_count <= read_count + 32'd1;
      end
      if (wren_RAM) begin
        write_count <= write_count + 32'd1;
      end
    end
  end

endmodule
